// File: rtl/uart_dec_pkg.sv
// Shared constants for the UART decimal line receiver: ASCII codes, bit-timing
// helpers and the bit-level receive FSM state encoding.
package uart_dec_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Wide enough for 9_999_999_999, the largest 10-digit line value.
  localparam int BIN_W = 34;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int half_bit(input int clk_freq, input int baud_rate);
    return clks_per_bit(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser and bit FSM. byte_vld/frame_err are
// strobes asserted in the cycle the stop bit is sampled.
module uart_rx_byte
  import uart_dec_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_vld,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta;
  logic             rx_s;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             tick_half;
  logic             tick_full;

  // Idle-high reset keeps a reset release from looking like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick_half = (cnt == HALF_M1);
  assign tick_full = (cnt == FULL_M1);

  assign data      = shreg;
  assign byte_vld  = (state == STOP) && tick_full && rx_s;
  assign frame_err = (state == STOP) && tick_full && !rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (tick_half) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_full) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_full) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : WAIT_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HI: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_dec_line_rx.sv
// UART 8N1 receiver that turns CR/LF-terminated ASCII decimal lines into packed BCD.
// Define UART_DEC_RX_BIN_EN to add value_bin_o, the same value in binary.
module uart_dec_line_rx
  import uart_dec_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int MAX_DIGITS = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    uart_rx_i,
  output logic [4*MAX_DIGITS-1:0] value_bcd_o,
  output logic                    value_valid_o,
  output logic                    frame_err_o,
  output logic                    fmt_err_o
`ifdef UART_DEC_RX_BIN_EN
  ,
  output logic [BIN_W-1:0]        value_bin_o
`endif
);

  localparam int BCD_W = 4 * MAX_DIGITS;
  localparam int DCNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [DCNT_W-1:0] MAX_CNT = DCNT_W'(MAX_DIGITS);

  logic [7:0]        rx_data;
  logic              rx_vld;
  logic              rx_frame_err;
  logic [BCD_W-1:0]  acc;
  logic [DCNT_W-1:0] count;
  logic              line_err;
  logic              is_digit;
  logic              is_term;
  logic [3:0]        digit;

  uart_rx_byte #(
    .CLKS_PER_BIT(clks_per_bit(CLK_FREQ, BAUD_RATE))
  ) u_rx_byte (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx       (uart_rx_i),
    .data     (rx_data),
    .byte_vld (rx_vld),
    .frame_err(rx_frame_err)
  );

  assign is_digit = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
  assign is_term  = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
  // For '0'..'9' the low nibble already equals byte - 0x30.
  assign digit    = rx_data[3:0];

`ifdef UART_DEC_RX_BIN_EN
  logic [BIN_W-1:0] bin_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_acc     <= '0;
      value_bin_o <= '0;
    end else if (rx_frame_err) begin
      bin_acc <= '0;
    end else if (rx_vld) begin
      if (is_digit) begin
        if (count < MAX_CNT && !line_err)
          bin_acc <= (bin_acc << 3) + (bin_acc << 1) + {{(BIN_W-4){1'b0}}, digit};
      end else if (is_term) begin
        if (!line_err && count != '0) value_bin_o <= bin_acc;
        bin_acc <= '0;
      end
    end
  end
`endif

  // Line decoder; a frame error discards whatever part of the line was collected.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_bcd_o   <= '0;
      value_valid_o <= 1'b0;
      frame_err_o   <= 1'b0;
      fmt_err_o     <= 1'b0;
      acc           <= '0;
      count         <= '0;
      line_err      <= 1'b0;
    end else begin
      value_valid_o <= 1'b0;
      fmt_err_o     <= 1'b0;
      frame_err_o   <= rx_frame_err;
      if (rx_frame_err) begin
        acc      <= '0;
        count    <= '0;
        line_err <= 1'b0;
      end else if (rx_vld) begin
        if (is_digit) begin
          if (count < MAX_CNT) begin
            acc   <= {acc[BCD_W-5:0], digit};
            count <= count + 1'b1;
          end else begin
            line_err <= 1'b1;
          end
        end else if (is_term) begin
          if (line_err) begin
            fmt_err_o <= 1'b1;
          end else if (count != '0) begin
            value_bcd_o   <= acc;
            value_valid_o <= 1'b1;
          end
          acc      <= '0;
          count    <= '0;
          line_err <= 1'b0;
        end else begin
          line_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_dec_line_rx.sv
// Bench for uart_dec_line_rx: serial driver, line-level reference model feeding an
// expected-event queue, and a pulse monitor that pops and compares.
module tb_uart_dec_line_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int MAXD     = 10;
  localparam int W        = 4 * MAXD;
  localparam int EV_W     = W + 2;

  localparam logic [1:0] K_VALID = 2'd1;
  localparam logic [1:0] K_FMT   = 2'd2;
  localparam logic [1:0] K_FRAME = 2'd3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         uart_rx_i = 1'b1;
  logic [W-1:0] value_bcd_o;
  logic         value_valid_o;
  logic         frame_err_o;
  logic         fmt_err_o;
`ifdef UART_DEC_RX_BIN_EN
  logic [33:0]  value_bin_o;
`endif

  always #5 clk = ~clk;

  uart_dec_line_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD),
    .MAX_DIGITS(MAXD)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .uart_rx_i    (uart_rx_i),
    .value_bcd_o  (value_bcd_o),
    .value_valid_o(value_valid_o),
    .frame_err_o  (frame_err_o),
    .fmt_err_o    (fmt_err_o)
`ifdef UART_DEC_RX_BIN_EN
    ,
    .value_bin_o  (value_bin_o)
`endif
  );

  logic [EV_W-1:0] exp_q[$];
  longint          exp_bin_q[$];
  int              n_cmp = 0;
  int              n_err = 0;
  int              n_pulses = 0;

  // Reference model state: digits of the current line, error flag, last accepted value.
  int              m_digits[$];
  bit              m_err = 1'b0;
  logic [W-1:0]    m_last = '0;
  longint          m_last_bin = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_char(input logic [7:0] c);
    logic [W-1:0] v;
    longint       d;
    if (c >= 8'h30 && c <= 8'h39) begin
      if (m_digits.size() < MAXD) m_digits.push_back(int'(c) - 48);
      else m_err = 1'b1;
    end else if (c == 8'h0D || c == 8'h0A) begin
      if (m_err) begin
        exp_q.push_back({K_FMT, W'(0)});
      end else if (m_digits.size() > 0) begin
        v = '0;
        d = 0;
        foreach (m_digits[i]) begin
          v = v * 16 + W'(m_digits[i]);
          d = d * 10 + longint'(m_digits[i]);
        end
        exp_q.push_back({K_VALID, v});
        exp_bin_q.push_back(d);
        m_last     = v;
        m_last_bin = d;
      end
      m_digits.delete();
      m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
  endfunction

  task automatic drive_byte(input logic [7:0] c, input bit stop_ok);
    uart_rx_i = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = c[i];
      repeat (CPB) @(posedge clk);
    end
    uart_rx_i = stop_ok;
    repeat (CPB) @(posedge clk);
    if (!stop_ok) begin
      repeat (2 * CPB) @(posedge clk);
      uart_rx_i = 1'b1;
      repeat (CPB) @(posedge clk);
    end
    uart_rx_i = 1'b1;
    repeat ($urandom_range(1, 4)) @(posedge clk);
  endtask

  task automatic send_char(input logic [7:0] c);
    model_char(c);
    drive_byte(c, 1'b1);
  endtask

  task automatic send_bad_stop(input logic [7:0] c);
    exp_q.push_back({K_FRAME, W'(0)});
    m_digits.delete();
    m_err = 1'b0;
    drive_byte(c, 1'b0);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic settle_check(input string name);
    repeat (4 * CPB) @(posedge clk);
    @(negedge clk);
    check({name, " pending"}, 64'(exp_q.size()), 64'd0);
    check({name, " value"}, 64'(value_bcd_o), 64'(m_last));
`ifdef UART_DEC_RX_BIN_EN
    check({name, " bin"}, 64'(value_bin_o), 64'(m_last_bin));
`endif
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    logic [EV_W-1:0] act;
    logic [EV_W-1:0] exp;
    logic [1:0]      kind;
    longint          eb;
    if (reset_n && (value_valid_o || fmt_err_o || frame_err_o)) begin
      n_pulses++;
      if (int'(value_valid_o) + int'(fmt_err_o) + int'(frame_err_o) > 1) kind = 2'd0;
      else if (value_valid_o) kind = K_VALID;
      else if (fmt_err_o) kind = K_FMT;
      else kind = K_FRAME;
      act = {kind, value_valid_o ? value_bcd_o : W'(0)};
      if (exp_q.size() == 0) begin
        check("unexpected pulse", 64'(act), 64'd0);
      end else begin
        exp = exp_q.pop_front();
        check("event", 64'(act), 64'(exp));
        if (exp[EV_W-1 -: 2] == K_VALID) begin
          eb = exp_bin_q.pop_front();
`ifdef UART_DEC_RX_BIN_EN
          check("event bin", 64'(value_bin_o), 64'(eb));
`endif
        end
      end
    end
  end

  initial begin
    #950_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] bad_chars[4];
    int         n;
    int         p;
    bad_chars[0] = 8'h61;
    bad_chars[1] = 8'h20;
    bad_chars[2] = 8'h2D;
    bad_chars[3] = 8'h2E;

    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset value", 64'(value_bcd_o), 64'd0);
    check("reset valid", 64'(value_valid_o), 64'd0);
    check("reset frame_err", 64'(frame_err_o), 64'd0);
    check("reset fmt_err", 64'(fmt_err_o), 64'd0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);

    send_str("0000012345\r\n");
    settle_check("ten digits");
    send_str("987\r\n");
    settle_check("three digits");
    send_str("\r\n");
    settle_check("blank line");
    send_str("12a4\r\n");
    settle_check("bad char");
    send_str("12345678901\r");
    settle_check("too long");
    send_char(8'h34);
    send_bad_stop(8'h32);
    settle_check("frame error");
    send_str("7\r\n");
    settle_check("after frame error");
    send_str("4294967296\r\n");
    settle_check("binary range");

    p = n_pulses;
    uart_rx_i = 1'b0;
    repeat (4) @(posedge clk);
    uart_rx_i = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    check("glitch pulses", 64'(n_pulses), 64'(p));

    send_char(8'h33);
    uart_rx_i = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    uart_rx_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midbyte reset value", 64'(value_bcd_o), 64'd0);
    check("midbyte reset pulses", 64'({value_valid_o, frame_err_o, fmt_err_o}), 64'd0);
    m_digits.delete();
    m_err      = 1'b0;
    m_last     = '0;
    m_last_bin = 0;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    send_str("5\r\n");
    settle_check("after reset");

    for (int line = 0; line < 25; line++) begin
      n = $urandom_range(0, 11);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 14) == 0) send_char(bad_chars[$urandom_range(0, 3)]);
        else if ($urandom_range(0, 19) == 0) send_bad_stop(8'h30 + 8'($urandom_range(0, 9)));
        else send_char(8'h30 + 8'($urandom_range(0, 9)));
      end
      case ($urandom_range(0, 2))
        0: send_str("\r\n");
        1: send_str("\r");
        default: send_str("\n");
      endcase
      settle_check("random line");
    end

    check("final queue", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
